uart_tx_arbiter: RTL and testbench

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_pkg.sv | 20 ++
 rtl/rr_arbiter.sv | 31 +++
 rtl/uart_tx_arbiter.sv | 141 ++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 430 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit arbiter.
// Holds the FSM state encoding and the standard baud rates.
package uart_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    PKT  = 1'b1
  } state_t;

  localparam int BAUD_W = 17;

  localparam logic [BAUD_W-1:0] BAUD_9600   = 17'd9600;
  localparam logic [BAUD_W-1:0] BAUD_19200  = 17'd19200;
  localparam logic [BAUD_W-1:0] BAUD_38400  = 17'd38400;
  localparam logic [BAUD_W-1:0] BAUD_57600  = 17'd57600;
  localparam logic [BAUD_W-1:0] BAUD_115200 = 17'd115200;

  localparam logic [BAUD_W-1:0] DEFAULT_BAUD = BAUD_9600;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: the search begins one past the last owner
// and returns both a one-hot grant and the matching index.
module rr_arbiter #(
  parameter int N_PORTS = 4,
  parameter int IW      = 2
) (
  input  logic [N_PORTS-1:0] req,
  input  logic [IW-1:0]      last_grant,
  output logic [N_PORTS-1:0] grant,
  output logic [IW-1:0]      grant_idx
);

  logic found;
  int   idx;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    for (int i = 0; i < N_PORTS; i++) begin
      idx = (int'(last_grant) + 1 + i) % N_PORTS;
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-level arbiter sharing one UART transmitter among N_PORTS AXI-Stream
// sources; each grant latches the winner's baud rate for the whole packet.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int N_PORTS = 4,
  parameter int TIMEOUT = 1024
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [N_PORTS*8-1:0]  s_axis_tdata_i,
  input  logic [N_PORTS-1:0]    s_axis_tvalid_i,
  input  logic [N_PORTS-1:0]    s_axis_tlast_i,
  output logic [N_PORTS-1:0]    s_axis_tready_o,
  input  logic [N_PORTS*17-1:0] baud_i,
  output logic [7:0]            m_axis_tdata_o,
  output logic                  m_axis_tvalid_o,
  output logic                  m_axis_tlast_o,
  input  logic                  m_axis_tready_i,
  output logic [16:0]           boudrate_o,
  output logic [N_PORTS-1:0]    grant_o,
  output logic                  busy_o,
  output logic                  timeout_o
);

  localparam int IW = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
  localparam int CW = $clog2(TIMEOUT) + 1;
  localparam logic [CW-1:0] CNT_LIMIT = CW'(TIMEOUT - 1);

  state_t             state_q, state_next;
  logic [N_PORTS-1:0] grant_q, grant_next;
  logic [IW-1:0]      owner_q, owner_next;
  logic [IW-1:0]      last_q, last_next;
  logic [16:0]        baud_q, baud_next;
  logic [CW-1:0]      cnt_q, cnt_next;
  logic               timeout_q, timeout_next;

  logic [N_PORTS-1:0] arb_grant;
  logic [IW-1:0]      arb_idx;
  logic [7:0]         sel_data;
  logic               sel_valid;
  logic               sel_last;
  logic               beat;

  rr_arbiter #(
    .N_PORTS (N_PORTS),
    .IW      (IW)
  ) u_rr_arbiter (
    .req        (s_axis_tvalid_i),
    .last_grant (last_q),
    .grant      (arb_grant),
    .grant_idx  (arb_idx)
  );

  assign sel_data  = s_axis_tdata_i[int'(owner_q)*8 +: 8];
  assign sel_valid = s_axis_tvalid_i[owner_q];
  assign sel_last  = s_axis_tlast_i[owner_q];
  assign beat      = (state_q == PKT) && sel_valid && m_axis_tready_i;

  always_comb begin
    state_next      = state_q;
    grant_next      = grant_q;
    owner_next      = owner_q;
    last_next       = last_q;
    baud_next       = baud_q;
    cnt_next        = cnt_q;
    timeout_next    = 1'b0;
    s_axis_tready_o = '0;
    m_axis_tdata_o  = '0;
    m_axis_tvalid_o = 1'b0;
    m_axis_tlast_o  = 1'b0;

    case (state_q)
      IDLE: begin
        if (|s_axis_tvalid_i) begin
          state_next = PKT;
          grant_next = arb_grant;
          owner_next = arb_idx;
          baud_next  = baud_i[int'(arb_idx)*17 +: 17];
          cnt_next   = '0;
        end
      end

      PKT: begin
        m_axis_tdata_o           = sel_data;
        m_axis_tvalid_o          = sel_valid;
        m_axis_tlast_o           = sel_last;
        s_axis_tready_o[owner_q] = m_axis_tready_i;

        // A beat always wins over an expiring idle counter.
        if (beat) begin
          cnt_next = '0;
          if (sel_last) begin
            state_next = IDLE;
            grant_next = '0;
            last_next  = owner_q;
          end
        end else if (cnt_q == CNT_LIMIT) begin
          state_next   = IDLE;
          grant_next   = '0;
          last_next    = owner_q;
          timeout_next = 1'b1;
        end else if (!sel_valid) begin
          cnt_next = cnt_q + CW'(1);
        end
      end

      default: begin
        state_next = IDLE;
        grant_next = '0;
      end
    endcase
  end

  // Last owner resets to the top port so the first search begins at port 0.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      owner_q   <= '0;
      last_q    <= IW'(N_PORTS - 1);
      baud_q    <= DEFAULT_BAUD;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_next;
      grant_q   <= grant_next;
      owner_q   <= owner_next;
      last_q    <= last_next;
      baud_q    <= baud_next;
      cnt_q     <= cnt_next;
      timeout_q <= timeout_next;
    end
  end

  assign grant_o    = grant_q;
  assign boudrate_o = baud_q;
  assign busy_o     = (state_q == PKT);
  assign timeout_o  = timeout_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: directed scenarios plus a random
// run compared cycle by cycle against a packet-level reference model.
module tb_uart_tx_arbiter;

  localparam int N  = 4;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic [N*8-1:0]  tdata;
  logic [N-1:0]    tvalid;
  logic [N-1:0]    tlast;
  logic [N-1:0]    tready;
  logic [N*17-1:0] baud;
  logic [7:0]      m_tdata;
  logic            m_tvalid;
  logic            m_tlast;
  logic            m_tready;
  logic [16:0]     boud;
  logic [N-1:0]    grant;
  logic            busy;
  logic            tmo;

  int tests = 0;
  int fails = 0;

  // Reference model state: owner is -1 while no packet is in progress.
  int          mo_owner;
  int          mo_last;
  int          mo_cnt;
  logic [16:0] mo_baud;
  logic        mo_to;

  always #5 clk = ~clk;

  uart_tx_arbiter #(
    .N_PORTS (N),
    .TIMEOUT (TO)
  ) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .s_axis_tdata_i  (tdata),
    .s_axis_tvalid_i (tvalid),
    .s_axis_tlast_i  (tlast),
    .s_axis_tready_o (tready),
    .baud_i          (baud),
    .m_axis_tdata_o  (m_tdata),
    .m_axis_tvalid_o (m_tvalid),
    .m_axis_tlast_o  (m_tlast),
    .m_axis_tready_i (m_tready),
    .boudrate_o      (boud),
    .grant_o         (grant),
    .busy_o          (busy),
    .timeout_o       (tmo)
  );

  task automatic model_edge();
    if (rst) begin
      mo_owner = -1;
      mo_last  = N - 1;
      mo_cnt   = 0;
      mo_baud  = 17'd9600;
      mo_to    = 1'b0;
    end else begin
      mo_to = 1'b0;
      if (mo_owner < 0) begin
        if (tvalid != 0) begin
          for (int i = 0; i < N; i++) begin
            if (mo_owner < 0 && tvalid[(mo_last + 1 + i) % N]) mo_owner = (mo_last + 1 + i) % N;
          end
          mo_baud = baud[mo_owner*17 +: 17];
          mo_cnt  = 0;
        end
      end else if (tvalid[mo_owner] && m_tready) begin
        mo_cnt = 0;
        if (tlast[mo_owner]) begin
          mo_last  = mo_owner;
          mo_owner = -1;
        end
      end else if (mo_cnt == TO - 1) begin
        mo_to    = 1'b1;
        mo_last  = mo_owner;
        mo_owner = -1;
      end else if (!tvalid[mo_owner]) begin
        mo_cnt = mo_cnt + 1;
      end
    end
  endtask

  function automatic logic [N-1:0] exp_grant();
    return (mo_owner < 0) ? '0 : N'(1 << mo_owner);
  endfunction

  function automatic logic [14:0] exp_axis();
    logic [14:0] r;
    r = '0;
    if (mo_owner >= 0)
      r = {tdata[mo_owner*8 +: 8], tvalid[mo_owner], tlast[mo_owner],
           (m_tready ? N'(1 << mo_owner) : N'(0))};
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic clear_inputs();
    tdata    = '0;
    tvalid   = '0;
    tlast    = '0;
    baud     = '0;
    m_tready = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [35:0] got;
    tvalid = 4'b1111;
    tlast  = 4'b1111;
    tdata  = 32'hA5A5_A5A5;
    m_tready = 1'b1;
    rst = 1'b1;
    tick();
    tick();
    @(negedge clk);
    got = {grant, busy, tmo, boud, m_tvalid, m_tlast, m_tdata, tready};
    tests++;
    if (got !== {4'b0, 1'b0, 1'b0, 17'd9600, 1'b0, 1'b0, 8'd0, 4'b0}) begin
      fails++;
      $display("[TB] FAIL reset_state: got %h expected %h", got,
               {4'b0, 1'b0, 1'b0, 17'd9600, 1'b0, 1'b0, 8'd0, 4'b0});
    end
    rst = 1'b0;
    clear_inputs();
    tick();
  endtask

  task automatic test_rr_pair();
    do_reset();
    baud[16:0]  = 17'd19200;
    baud[50:34] = 17'd57600;
    tdata[7:0]   = 8'h11;
    tdata[23:16] = 8'h33;
    tvalid = 4'b0101;
    tlast  = 4'b0101;
    m_tready = 1'b1;
    tick();
    @(negedge clk);
    tests++;
    if (grant !== 4'b0001 || boud !== 17'd19200 || m_tdata !== 8'h11) begin
      fails++;
      $display("[TB] FAIL pair_first: grant %b baud %0d data %h, expected 0001 19200 11", grant, boud, m_tdata);
    end
    tick();
    tvalid[0] = 1'b0;
    @(negedge clk);
    tests++;
    if (grant !== 4'b0000) begin
      fails++;
      $display("[TB] FAIL pair_gap: grant %b expected 0000", grant);
    end
    tick();
    @(negedge clk);
    tests++;
    if (grant !== 4'b0100 || boud !== 17'd57600 || m_tdata !== 8'h33) begin
      fails++;
      $display("[TB] FAIL pair_second: grant %b baud %0d data %h, expected 0100 57600 33", grant, boud, m_tdata);
    end
    tick();
    clear_inputs();
    tick();
  endtask

  task automatic test_round_robin();
    logic [N-1:0] expected;
    do_reset();
    tvalid = 4'b1111;
    tlast  = 4'b1111;
    m_tready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      expected = (c % 2 == 1) ? N'(1 << ((c / 2) % N)) : N'(0);
      tests++;
      if (grant !== expected) begin
        fails++;
        $display("[TB] FAIL rr_cycle%0d: grant %b expected %b", c, grant, expected);
      end
      tick();
    end
    clear_inputs();
    tick();
  endtask

  task automatic test_stall();
    logic [7:0] bytes [3];
    bit stall_bad;
    bytes[0] = 8'hC1;
    bytes[1] = 8'hC2;
    bytes[2] = 8'hC3;
    stall_bad = 1'b0;
    do_reset();
    tvalid = 4'b0010;
    tdata[15:8] = bytes[0];
    tick();
    @(negedge clk);
    tests++;
    if (grant !== 4'b0010) begin
      fails++;
      $display("[TB] FAIL stall_grant: grant %b expected 0010", grant);
    end
    for (int j = 0; j < 3; j++) begin
      tdata[15:8] = bytes[j];
      tlast[1] = (j == 2);
      m_tready = 1'b1;
      @(negedge clk);
      tests++;
      if (m_tdata !== bytes[j] || m_tlast !== (j == 2) || m_tvalid !== 1'b1 || tready !== 4'b0010) begin
        fails++;
        $display("[TB] FAIL stall_byte%0d: data %h last %b valid %b ready %b, expected %h %b 1 0010",
                 j, m_tdata, m_tlast, m_tvalid, tready, bytes[j], (j == 2));
      end
      tick();
      if (j < 2) begin
        m_tready = 1'b0;
        repeat (100) begin
          @(negedge clk);
          if (tmo !== 1'b0 || busy !== 1'b1) stall_bad = 1'b1;
          tick();
        end
      end
    end
    tvalid = '0;
    tests++;
    if (stall_bad || grant !== 4'b0000 || busy !== 1'b0) begin
      fails++;
      $display("[TB] FAIL stall_end: stall_bad %b grant %b busy %b, expected 0 0000 0", stall_bad, grant, busy);
    end
    clear_inputs();
    tick();
  endtask

  task automatic test_timeout();
    int k;
    do_reset();
    tvalid = 4'b1000;
    tdata[31:24] = 8'h5A;
    m_tready = 1'b1;
    tick();
    tests++;
    if (grant !== 4'b1000) begin
      fails++;
      $display("[TB] FAIL to_grant: grant %b expected 1000", grant);
    end
    tick();
    tvalid = '0;
    k = 0;
    while (grant !== 4'b0000 && k < 40) begin
      tick();
      k++;
    end
    tests++;
    if (k != TO || tmo !== 1'b1) begin
      fails++;
      $display("[TB] FAIL to_release: cycles %0d timeout %b, expected %0d 1", k, tmo, TO);
    end
    tick();
    tests++;
    if (tmo !== 1'b0 || grant !== 4'b0000) begin
      fails++;
      $display("[TB] FAIL to_pulse: timeout %b grant %b, expected 0 0000", tmo, grant);
    end
    clear_inputs();
    tick();
  endtask

  task automatic test_baud_hold();
    do_reset();
    baud[16:0] = 17'd9600;
    tvalid = 4'b0001;
    tick();
    tests++;
    if (boud !== 17'd9600 || grant !== 4'b0001) begin
      fails++;
      $display("[TB] FAIL baud_grant: baud %0d grant %b, expected 9600 0001", boud, grant);
    end
    baud[16:0] = 17'd115200;
    repeat (5) tick();
    tests++;
    if (boud !== 17'd9600) begin
      fails++;
      $display("[TB] FAIL baud_mid: baud %0d expected 9600", boud);
    end
    tlast[0] = 1'b1;
    m_tready = 1'b1;
    tick();
    tests++;
    if (boud !== 17'd9600 || grant !== 4'b0000) begin
      fails++;
      $display("[TB] FAIL baud_idle: baud %0d grant %b, expected 9600 0000", boud, grant);
    end
    tick();
    tests++;
    if (boud !== 17'd115200 || grant !== 4'b0001) begin
      fails++;
      $display("[TB] FAIL baud_next: baud %0d grant %b, expected 115200 0001", boud, grant);
    end
    clear_inputs();
    tick();
  endtask

  task automatic test_reset_mid();
    logic [35:0] got;
    do_reset();
    tvalid = 4'b0001;
    tlast  = 4'b0001;
    m_tready = 1'b1;
    tick();
    tick();
    tvalid = 4'b0010;
    tlast  = 4'b0000;
    m_tready = 1'b0;
    baud[33:17] = 17'd38400;
    tick();
    tests++;
    if (grant !== 4'b0010 || boud !== 17'd38400) begin
      fails++;
      $display("[TB] FAIL rstmid_grant: grant %b baud %0d, expected 0010 38400", grant, boud);
    end
    tvalid = 4'b0011;
    rst = 1'b1;
    tick();
    got = {grant, busy, tmo, boud, m_tvalid, m_tlast, m_tdata, tready};
    tests++;
    if (got !== {4'b0, 1'b0, 1'b0, 17'd9600, 1'b0, 1'b0, 8'd0, 4'b0}) begin
      fails++;
      $display("[TB] FAIL rstmid_state: got %h expected %h", got,
               {4'b0, 1'b0, 1'b0, 17'd9600, 1'b0, 1'b0, 8'd0, 4'b0});
    end
    rst = 1'b0;
    tick();
    tests++;
    if (grant !== 4'b0001) begin
      fails++;
      $display("[TB] FAIL rstmid_next: grant %b expected 0001", grant);
    end
    clear_inputs();
    tick();
  endtask

  task automatic test_random();
    int mode;
    do_reset();
    mode = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (cyc % 64 == 0) mode = $urandom_range(0, 2);
      rst = ($urandom_range(0, 299) == 0);
      case (mode)
        0:       tvalid = N'($urandom);
        1:       tvalid = N'($urandom & $urandom & $urandom);
        default: tvalid = N'($urandom | $urandom);
      endcase
      for (int p = 0; p < N; p++) tlast[p] = ($urandom_range(0, 3) == 0);
      tdata    = (N*8)'($urandom);
      baud     = (N*17)'({$urandom, $urandom, $urandom});
      m_tready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      tests++;
      if (grant !== exp_grant()) begin
        fails++;
        $display("[TB] FAIL rand_grant cycle %0d: got %b expected %b", cyc, grant, exp_grant());
      end
      tests++;
      if ({m_tdata, m_tvalid, m_tlast, tready} !== exp_axis()) begin
        fails++;
        $display("[TB] FAIL rand_axis cycle %0d: got %h expected %h", cyc,
                 {m_tdata, m_tvalid, m_tlast, tready}, exp_axis());
      end
      tests++;
      if (boud !== mo_baud) begin
        fails++;
        $display("[TB] FAIL rand_baud cycle %0d: got %0d expected %0d", cyc, boud, mo_baud);
      end
      tests++;
      if ({busy, tmo} !== {(mo_owner >= 0), mo_to}) begin
        fails++;
        $display("[TB] FAIL rand_status cycle %0d: busy/timeout %b expected %b", cyc,
                 {busy, tmo}, {(mo_owner >= 0), mo_to});
      end
      tick();
    end
    rst = 1'b0;
    clear_inputs();
    tick();
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
    mo_owner = -1;
    mo_last  = N - 1;
    mo_cnt   = 0;
    mo_baud  = 17'd9600;
    mo_to    = 1'b0;
    test_reset();
    test_rr_pair();
    test_round_robin();
    test_stall();
    test_timeout();
    test_baud_hold();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
